// File: rtl/spi_slave_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_slave_pkg
//  Brief    : Shared constants and types for the SPI slave and its bus model.
//  Revision : 1.0
// ============================================================================
package spi_slave_pkg;

    localparam int unsigned SPI_WIDTH = 16;
    localparam int unsigned SPI_MODE  = 3;

    typedef enum logic {
        EDGE_RISE = 1'b0,
        EDGE_FALL = 1'b1
    } spi_edge_e;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage : spi_slave_pkg
`default_nettype wire

// File: rtl/spi_slave_if.sv
`default_nettype none
// ============================================================================
//  Module   : spi_slave_if
//  Brief    : Parallel/serial data bundle between SPI master pins and slave.
//  Revision : 1.0
// ============================================================================
interface spi_slave_if #(
    parameter int unsigned WIDTH = spi_slave_pkg::SPI_WIDTH
) ();

    logic             ten;
    logic [WIDTH-1:0] tdata;
    logic             mosi;
    logic             miso;
    logic             done;
    logic [WIDTH-1:0] rdata;

    modport slave (
        input  ten,
        input  tdata,
        input  mosi,
        output miso,
        output done,
        output rdata
    );

    modport master (
        output ten,
        output tdata,
        output mosi,
        input  miso,
        input  done,
        input  rdata
    );

endinterface : spi_slave_if
`default_nettype wire

// File: rtl/spi_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_shift_reg
//  Brief    : WIDTH-bit left shift register with parallel load, on a chosen
//             clock edge.
//  Revision : 1.0
// ============================================================================
module spi_shift_reg
    import spi_slave_pkg::*;
#(
    parameter int unsigned WIDTH = SPI_WIDTH,
    parameter spi_edge_e   EDGE  = EDGE_RISE
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load,
    input  wire logic [WIDTH-1:0] i_load_data,
    input  wire logic             i_shift_en,
    input  wire logic             i_shift_in,
    output logic      [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;

    // Load takes priority over shift.
    always_comb begin
        w_next = r_q;
        if (i_load) begin
            w_next = i_load_data;
        end else if (i_shift_en) begin
            w_next = {r_q[WIDTH-2:0], i_shift_in};
        end
    end

    generate
        if (EDGE == EDGE_FALL) begin : g_fall
            always_ff @(negedge clk or posedge rst) begin
                if (rst) begin
                    r_q <= '0;
                end else begin
                    r_q <= w_next;
                end
            end
        end else begin : g_rise
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_q <= '0;
                end else begin
                    r_q <= w_next;
                end
            end
        end
    endgenerate

    assign o_q = r_q;

endmodule : spi_shift_reg
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
//  Module   : spi_slave
//  Brief    : Mode-3 MSB-first SPI slave clocked by sck; framing by bit count.
//  Revision : 1.0
// ============================================================================
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int unsigned WIDTH = SPI_WIDTH
) (
    input  wire logic       sck,
    input  wire logic       rstb,
    spi_slave_if.slave      bus
);

    localparam int unsigned     NBW  = cnt_width(WIDTH);
    localparam logic [NBW-1:0]  LAST = NBW'(WIDTH - 1);

    logic [NBW-1:0]   r_nbit;
    logic [WIDTH-1:0] r_rdata;
    logic             r_done;
    logic             r_miso;

    logic [WIDTH-1:0] w_rsr;
    logic [WIDTH-1:0] w_tsr;
    logic [WIDTH-1:0] w_tload;
    logic             w_frame_start;
    logic             w_unused_bits;

    assign w_frame_start = (r_nbit == '0);
    assign w_tload       = {bus.tdata[WIDTH-2:0], 1'b0};

    spi_shift_reg #(
        .WIDTH (WIDTH),
        .EDGE  (EDGE_RISE)
    ) u_rx_sr (
        .clk         (sck),
        .rst         (rstb),
        .i_load      (1'b0),
        .i_load_data ({WIDTH{1'b0}}),
        .i_shift_en  (1'b1),
        .i_shift_in  (bus.mosi),
        .o_q         (w_rsr)
    );

    // tdata is captured at frame start; its MSB goes straight to miso below.
    spi_shift_reg #(
        .WIDTH (WIDTH),
        .EDGE  (EDGE_FALL)
    ) u_tx_sr (
        .clk         (sck),
        .rst         (rstb),
        .i_load      (w_frame_start),
        .i_load_data (w_tload),
        .i_shift_en  (1'b1),
        .i_shift_in  (1'b0),
        .o_q         (w_tsr)
    );

    assign w_unused_bits = ^{w_rsr[WIDTH-1], w_tsr[WIDTH-2:0]};

    always_ff @(posedge sck or posedge rstb) begin
        if (rstb) begin
            r_nbit  <= '0;
            r_rdata <= '0;
            r_done  <= 1'b0;
        end else if (r_nbit == LAST) begin
            r_rdata <= {w_rsr[WIDTH-2:0], bus.mosi};
            r_done  <= 1'b1;
            r_nbit  <= '0;
        end else begin
            r_nbit  <= r_nbit + NBW'(1);
            r_done  <= 1'b0;
        end
    end

    // ten gates the output only; the transmit register keeps shifting.
    always_ff @(negedge sck or posedge rstb) begin
        if (rstb) begin
            r_miso <= 1'b0;
        end else if (w_frame_start) begin
            r_miso <= bus.ten & bus.tdata[WIDTH-1];
        end else begin
            r_miso <= bus.ten & w_tsr[WIDTH-1];
        end
    end

    assign bus.rdata = r_rdata;
    assign bus.done  = r_done;
    assign bus.miso  = r_miso;

endmodule : spi_slave
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_slave
//  Brief    : Directed self-checking bench for spi_slave (mode 3, 16-bit).
//  Revision : 1.0
// ============================================================================
module tb_spi_slave;

    localparam int unsigned WIDTH = 16;

    logic sck;
    logic rstb;

    int   n_checks;
    int   n_fails;
    logic [WIDTH-1:0] exp_rdata;

    spi_slave_if #(.WIDTH(WIDTH)) bus_if ();

    spi_slave #(
        .WIDTH (WIDTH)
    ) dut (
        .sck  (sck),
        .rstb (rstb),
        .bus  (bus_if.slave)
    );

    // Free-running sck, idles high: falls at 5, 15, ... rises at 10, 20, ...
    initial begin
        sck = 1'b1;
        forever #5 sck = ~sck;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [WIDTH-1:0] got,
                             input logic [WIDTH-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %04h expected %04h", tag, got, exp);
        end
    endtask

    // Entered and left just after a rising edge; rstb held for n full periods.
    task automatic reset_cycles(input int n);
        rstb = 1'b1;
        exp_rdata = '0;
        #1;
        check_val("rst_async_rdata", bus_if.rdata, '0);
        check_val("rst_async_done",  {15'b0, bus_if.done}, '0);
        check_val("rst_async_miso",  {15'b0, bus_if.miso}, '0);
        for (int i = 0; i < n; i++) begin
            @(negedge sck); #2;
            check_val("rst_miso", {15'b0, bus_if.miso}, '0);
            @(posedge sck); #2;
            check_val("rst_done",  {15'b0, bus_if.done}, '0);
            check_val("rst_rdata", bus_if.rdata, '0);
        end
        rstb = 1'b0;
    endtask

    // One frame (or its first nbits bits). ten_mask bit 15-i is ten for bit i.
    task automatic run_frame(input logic [WIDTH-1:0] mo, input logic [WIDTH-1:0] td,
                             input logic [WIDTH-1:0] ten_mask, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            bus_if.ten = ten_mask[15-i];
            if (i == 0)
                bus_if.tdata = td;
            else if (i == 1)
                bus_if.tdata = ~td;
            @(negedge sck); #2;
            check_val($sformatf("miso[%0d]", i), {15'b0, bus_if.miso},
                      {15'b0, ten_mask[15-i] & td[15-i]});
            bus_if.mosi = mo[15-i];
            @(posedge sck); #2;
            if (i == 15)
                exp_rdata = mo;
            check_val($sformatf("done[%0d]", i), {15'b0, bus_if.done}, {15'b0, (i == 15)});
            check_val($sformatf("rdata[%0d]", i), bus_if.rdata, exp_rdata);
        end
    endtask

    initial begin
        n_checks     = 0;
        n_fails      = 0;
        exp_rdata    = '0;
        rstb         = 1'b1;
        bus_if.ten   = 1'b0;
        bus_if.tdata = '0;
        bus_if.mosi  = 1'b0;

        reset_cycles(3);

        // Receive only
        run_frame(16'hA5C3, 16'h0000, 16'h0000, 16);
        // Transmit, with tdata disturbed mid-frame
        run_frame(16'h0000, 16'hAAAA, 16'hFFFF, 16);
        run_frame(16'h0000, 16'hAFAF, 16'hFFFF, 16);
        // Back-to-back receive
        run_frame(16'h1234, 16'h0000, 16'h0000, 16);
        run_frame(16'hFFFF, 16'h0000, 16'h0000, 16);
        // ten dropped after bit 4
        run_frame(16'h0000, 16'hFFFF, 16'hF800, 16);
        // Abort after 5 bits, then a clean frame
        run_frame(16'hFFFF, 16'hFFFF, 16'hFFFF, 5);
        reset_cycles(2);
        run_frame(16'h8001, 16'h0000, 16'h0000, 16);

        // done must fall on the following rising edge
        @(negedge sck); #2;
        @(posedge sck); #2;
        check_val("done_tail",  {15'b0, bus_if.done}, '0);
        check_val("rdata_tail", bus_if.rdata, 16'h8001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_spi_slave
`default_nettype wire
